// File: rtl/ps2_scan_decoder_pkg.sv
// Shared keyboard definitions: decoder state encoding, set-2 scan-code
// constants and the key-event record passed between decoder stages.
package ps2_scan_decoder_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_BRK  = 2'd2
  } kbd_state_e;

  localparam logic [DATA_W-1:0] EXT_CODE    = 8'hE0;
  localparam logic [DATA_W-1:0] BRK_CODE    = 8'hF0;
  localparam logic [DATA_W-1:0] LSHIFT_CODE = 8'h12;
  localparam logic [DATA_W-1:0] RSHIFT_CODE = 8'h59;

  typedef struct packed {
    logic [DATA_W-1:0] code;
    logic              ext;
    logic              rel;
  } kbd_event_t;

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte-in / key-event-out bus of the scan decoder. The master drives
// received bytes and consumes events; the slave is the decoder itself.
interface ps2_scan_decoder_if;
  import ps2_scan_decoder_pkg::*;

  logic              i_rx_done_tick;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_code;
  logic              o_ext;
  logic              o_release;
  logic              o_shift;
  logic              o_overflow;
  logic              i_ovf_clr;

  modport master (
    output i_rx_done_tick, i_data, i_ready, i_ovf_clr,
    input  o_valid, o_code, o_ext, o_release, o_shift, o_overflow
  );

  modport slave (
    input  i_rx_done_tick, i_data, i_ready, i_ovf_clr,
    output o_valid, o_code, o_ext, o_release, o_shift, o_overflow
  );

endinterface

// File: rtl/ps2_scan_decoder_event_reg.sv
// One-entry valid/ready key-event register; an event arriving while the
// held one is still unconsumed is dropped and flagged as overflow.
module ps2_scan_decoder_event_reg
  import ps2_scan_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_emit,
  input  kbd_event_t i_event,
  input  logic       i_ready,
  input  logic       i_ovf_clr,
  output logic       o_valid,
  output kbd_event_t o_event,
  output logic       o_overflow
);

  logic can_load;
  logic drop;

  assign can_load = !o_valid || i_ready;
  assign drop     = i_emit && !can_load;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid    <= 1'b0;
      o_event    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_emit && can_load) begin
        o_valid <= 1'b1;
        o_event <= i_event;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear request must stay visible.
      if (drop)
        o_overflow <= 1'b1;
      else if (i_ovf_clr)
        o_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan decoder: folds E0/F0 prefixes into single key events
// and tracks the live left/right shift state.
module ps2_scan_decoder #(
  parameter logic [7:0] EXT_CODE    = ps2_scan_decoder_pkg::EXT_CODE,
  parameter logic [7:0] BRK_CODE    = ps2_scan_decoder_pkg::BRK_CODE,
  parameter logic [7:0] LSHIFT_CODE = ps2_scan_decoder_pkg::LSHIFT_CODE,
  parameter logic [7:0] RSHIFT_CODE = ps2_scan_decoder_pkg::RSHIFT_CODE
) (
  input logic               i_clk,
  input logic               i_reset_n,
  ps2_scan_decoder_if.slave bus
);
  import ps2_scan_decoder_pkg::*;

  kbd_state_e state, state_nx;
  logic       ext_pend, ext_pend_nx;
  logic       emit_p0;
  kbd_event_t ev_p0;
  kbd_event_t ev_p1;
  logic       lshift, rshift;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      ext_pend <= 1'b0;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
    end else begin
      state    <= state_nx;
      ext_pend <= ext_pend_nx;
      // Shift state follows every emitted event, dropped or not.
      if (emit_p0 && !ev_p0.ext) begin
        if (ev_p0.code == LSHIFT_CODE) lshift <= !ev_p0.rel;
        if (ev_p0.code == RSHIFT_CODE) rshift <= !ev_p0.rel;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    ext_pend_nx = ext_pend;
    emit_p0     = 1'b0;
    ev_p0.code  = bus.i_data;
    ev_p0.ext   = 1'b0;
    ev_p0.rel   = 1'b0;
    if (bus.i_rx_done_tick) begin
      case (state)
        S_IDLE: begin
          if (bus.i_data == EXT_CODE) begin
            state_nx    = S_EXT;
            ext_pend_nx = 1'b1;
          end else if (bus.i_data == BRK_CODE) begin
            state_nx    = S_BRK;
            ext_pend_nx = 1'b0;
          end else begin
            emit_p0 = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.i_data == BRK_CODE) begin
            state_nx = S_BRK;
          end else if (bus.i_data != EXT_CODE) begin
            emit_p0     = 1'b1;
            ev_p0.ext   = 1'b1;
            state_nx    = S_IDLE;
            ext_pend_nx = 1'b0;
          end
        end
        S_BRK: begin
          // E0 after F0 means a lost byte; restart as an extended make.
          if (bus.i_data == EXT_CODE) begin
            state_nx    = S_EXT;
            ext_pend_nx = 1'b1;
          end else if (bus.i_data != BRK_CODE) begin
            emit_p0     = 1'b1;
            ev_p0.ext   = ext_pend;
            ev_p0.rel   = 1'b1;
            state_nx    = S_IDLE;
            ext_pend_nx = 1'b0;
          end
        end
        default: begin
          state_nx    = S_IDLE;
          ext_pend_nx = 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: registered event output ----
  ps2_scan_decoder_event_reg u_event_reg (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_emit     (emit_p0),
    .i_event    (ev_p0),
    .i_ready    (bus.i_ready),
    .i_ovf_clr  (bus.i_ovf_clr),
    .o_valid    (bus.o_valid),
    .o_event    (ev_p1),
    .o_overflow (bus.o_overflow)
  );

  assign bus.o_code    = ev_p1.code;
  assign bus.o_ext     = ev_p1.ext;
  assign bus.o_release = ev_p1.rel;
  assign bus.o_shift   = lshift | rshift;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: expected events are queued as
// bytes are sent and matched against every accepted output event.
module tb_ps2_scan_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // Every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got code=%h ext=%b rel=%b, expected none",
                 bus.o_code, bus.o_ext, bus.o_release);
      end else begin
        ev_t exp_ev;
        exp_ev = sb.pop_front();
        if ({bus.o_code, bus.o_ext, bus.o_release} !== exp_ev) begin
          bad++;
          $display("FAIL event: got code=%h ext=%b rel=%b, expected code=%h ext=%b rel=%b",
                   bus.o_code, bus.o_ext, bus.o_release, exp_ev.code, exp_ev.ext, exp_ev.rel);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_done_tick = 1'b1;
    bus.i_data = b;
    @(posedge clk); #1;
    bus.i_rx_done_tick = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic e, input logic r);
    sb.push_back({c, e, r});
  endtask

  task automatic check_drained(input string name);
    int budget = 20;
    while ((sb.size() != 0 || bus.o_valid) && budget > 0) begin
      @(posedge clk); budget--;
    end
    #1;
    total++;
    if (sb.size() != 0 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d valid=%b, expected pending=0 valid=0",
               name, sb.size(), bus.o_valid);
    end
  endtask

  task automatic check_outputs_reset(input string name);
    total++;
    if ({bus.o_valid, bus.o_code, bus.o_ext, bus.o_release, bus.o_shift, bus.o_overflow} !== 13'd0) begin
      bad++;
      $display("FAIL %s: valid=%b code=%h ext=%b rel=%b shift=%b ovf=%b, expected all zero",
               name, bus.o_valid, bus.o_code, bus.o_ext, bus.o_release, bus.o_shift, bus.o_overflow);
    end
  endtask

  task automatic check_shift(input string name, input logic exp_s);
    total++;
    if (bus.o_shift !== exp_s) begin
      bad++;
      $display("FAIL %s: shift=%b, expected %b", name, bus.o_shift, exp_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    idle(2);
    check_outputs_reset("reset_state");
    rst_n = 1'b1;
    idle(1);
    check_outputs_reset("after_reset");
  endtask

  task automatic test_basic();
    bus.i_ready = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    total++;
    if ({bus.o_valid, bus.o_code, bus.o_ext, bus.o_release} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_latency: valid=%b code=%h ext=%b rel=%b, expected 1 1c 0 0",
               bus.o_valid, bus.o_code, bus.o_ext, bus.o_release);
    end
    idle(1);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_clear: valid=%b, expected 0", bus.o_valid);
    end
    check_drained("basic");
  endtask

  task automatic test_prefix();
    expect_ev(8'h75, 1'b1, 1'b1);
    send(8'hE0);
    send(8'hF0);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL prefix_no_event: valid=%b, expected 0", bus.o_valid);
    end
    send(8'h75);
    check_drained("prefix");
  endtask

  task automatic test_shift();
    expect_ev(8'h12, 1'b0, 1'b0);
    send(8'h12);
    check_shift("lshift_make", 1'b1);
    expect_ev(8'h12, 1'b1, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h12);
    check_shift("ext_release_ignored", 1'b1);
    expect_ev(8'h12, 1'b0, 1'b1);
    send(8'hF0);
    check_shift("brk_prefix_hold", 1'b1);
    send(8'h12);
    check_shift("lshift_break", 1'b0);
    expect_ev(8'h12, 1'b1, 1'b0);
    send(8'hE0); send(8'h12);
    check_shift("ext_make_ignored", 1'b0);
    expect_ev(8'h59, 1'b0, 1'b0);
    send(8'h59);
    check_shift("rshift_make", 1'b1);
    expect_ev(8'h59, 1'b0, 1'b1);
    send(8'hF0); send(8'h59);
    check_shift("rshift_break", 1'b0);
    check_drained("shift");
  endtask

  task automatic test_overflow();
    bus.i_ready = 1'b0;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    send(8'h32);
    total++;
    if ({bus.o_valid, bus.o_code, bus.o_overflow} !== {1'b1, 8'h1C, 1'b1}) begin
      bad++;
      $display("FAIL ovf_hold: valid=%b code=%h ovf=%b, expected 1 1c 1",
               bus.o_valid, bus.o_code, bus.o_overflow);
    end
    bus.i_ovf_clr = 1'b1;
    idle(1);
    bus.i_ovf_clr = 1'b0;
    total++;
    if (bus.o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%b, expected 0", bus.o_overflow);
    end
    // Dropped events still drive shift tracking; drop beats clear.
    bus.i_ovf_clr = 1'b1;
    send(8'h12);
    bus.i_ovf_clr = 1'b0;
    check_shift("dropped_make_shift", 1'b1);
    total++;
    if ({bus.o_overflow, bus.o_code} !== {1'b1, 8'h1C}) begin
      bad++;
      $display("FAIL ovf_set_priority: ovf=%b code=%h, expected 1 1c",
               bus.o_overflow, bus.o_code);
    end
    send(8'hF0); send(8'h12);
    check_shift("dropped_break_shift", 1'b0);
    bus.i_ovf_clr = 1'b1;
    idle(1);
    bus.i_ovf_clr = 1'b0;
    bus.i_ready = 1'b1;
    check_drained("overflow");
  endtask

  task automatic test_resync();
    expect_ev(8'h6B, 1'b1, 1'b0);
    send(8'hF0); send(8'hE0); send(8'h6B);
    check_drained("resync");
  endtask

  task automatic test_reset_mid_seq();
    send(8'hE0);
    rst_n = 1'b0;
    bus.i_rx_done_tick = 1'b1;
    bus.i_data = 8'h55;
    idle(1);
    bus.i_rx_done_tick = 1'b0;
    check_outputs_reset("mid_reset_state");
    rst_n = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    check_drained("mid_reset");
  endtask

  task automatic test_back_to_back();
    bus.i_ready = 1'b1;
    expect_ev(8'h1C, 1'b0, 1'b0);
    expect_ev(8'h32, 1'b0, 1'b0);
    expect_ev(8'h74, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.i_rx_done_tick = 1'b1;
    bus.i_data = 8'h1C;
    @(posedge clk); #1;
    bus.i_data = 8'h32;
    @(posedge clk); #1;
    bus.i_data = 8'hE0;
    @(posedge clk); #1;
    bus.i_data = 8'h74;
    @(posedge clk); #1;
    bus.i_rx_done_tick = 1'b0;
    total++;
    if (bus.o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_overflow: ovf=%b, expected 0", bus.o_overflow);
    end
    check_drained("back_to_back");
  endtask

  initial begin
    bus.i_rx_done_tick = 1'b0;
    bus.i_data = 8'h00;
    bus.i_ready = 1'b1;
    bus.i_ovf_clr = 1'b0;
    test_reset();
    test_basic();
    test_prefix();
    test_shift();
    test_overflow();
    test_resync();
    test_reset_mid_seq();
    test_back_to_back();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
